// File: rtl/stdmacro_dffe_pipe_pkg.sv
// Shared constants and helpers for the elastic DFF-with-enable pipeline macro.
package stdmacro_dffe_pipe_pkg;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return unsigned'($clog2(depth + 1));
    endfunction

    // A stage can take a new beat if it is empty or its own beat moves on this cycle.
    function automatic logic stage_ready(input logic valid, input logic ready_next);
        return !valid || ready_next;
    endfunction

endpackage

// File: rtl/stdmacro_dffe_pipe_if.sv
// Valid/ready/data handshake bundle used on both sides of the pipeline.
interface stdmacro_dffe_pipe_if #(
    parameter int unsigned DFF_WIDTH = 32
) ();
    logic                 valid;
    logic                 ready;
    logic [DFF_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stdmacro_dffe_pipe_stage.sv
// One pipeline stage: valid flag plus payload register loaded only for real beats.
module stdmacro_dffe_pipe_stage #(
    parameter int unsigned          DFF_WIDTH   = 32,
    parameter logic [DFF_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 en,
    input  logic                 up_valid,
    input  logic [DFF_WIDTH-1:0] up_data,
    output logic                 v,
    output logic [DFF_WIDTH-1:0] d
);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            v <= 1'b0;
            d <= RESET_VALUE;
        end else if (en) begin
            v <= up_valid;
            // Bubbles leave the payload untouched.
            if (up_valid) begin
                d <= up_data;
            end
        end
    end

endmodule

// File: rtl/stdmacro_dffe_pipe.sv
// Multi-stage elastic pipeline register: per-stage ready chain, bubble collapse,
// synchronous flush and a combinational occupancy count.
module stdmacro_dffe_pipe
    import stdmacro_dffe_pipe_pkg::*;
#(
    parameter int unsigned          DFF_WIDTH   = 32,
    parameter int unsigned          PIPE_DEPTH  = 2,
    parameter logic [DFF_WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned          CNT_WIDTH   = cnt_width(PIPE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  flush,
    stdmacro_dffe_pipe_if.slave   in_bus,
    stdmacro_dffe_pipe_if.master  out_bus,
    output logic [CNT_WIDTH-1:0]  occupancy
);

    logic [PIPE_DEPTH-1:0]                v;
    logic [PIPE_DEPTH-1:0]                rdy;
    logic [PIPE_DEPTH-1:0]                en;
    logic [PIPE_DEPTH-1:0]                up_valid_raw;
    logic [PIPE_DEPTH-1:0]                up_valid;
    logic [PIPE_DEPTH-1:0][DFF_WIDTH-1:0] d;
    logic [PIPE_DEPTH-1:0][DFF_WIDTH-1:0] up_data;

    always_comb begin
        rdy = '0;
        rdy[PIPE_DEPTH-1] = stage_ready(v[PIPE_DEPTH-1], out_bus.ready);
        for (int i = int'(PIPE_DEPTH) - 2; i >= 0; i--) begin
            rdy[i] = stage_ready(v[i], rdy[i+1]);
        end
    end

    if (PIPE_DEPTH == 1) begin : g_single
        assign up_valid_raw = in_bus.valid;
        assign up_data      = in_bus.data;
    end else begin : g_multi
        assign up_valid_raw = {v[PIPE_DEPTH-2:0], in_bus.valid};
        assign up_data      = {d[PIPE_DEPTH-2:0], in_bus.data};
    end

    // Flush opens every enable with a zero valid, clearing all stages but keeping data.
    assign up_valid = up_valid_raw & ~{PIPE_DEPTH{flush}};
    assign en       = rdy | {PIPE_DEPTH{flush}};

    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
        stdmacro_dffe_pipe_stage #(
            .DFF_WIDTH   (DFF_WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk      (clk),
            .aresetn  (aresetn),
            .en       (en[i]),
            .up_valid (up_valid[i]),
            .up_data  (up_data[i]),
            .v        (v[i]),
            .d        (d[i])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
            occupancy = occupancy + CNT_WIDTH'(v[i]);
        end
    end

    assign in_bus.ready  = rdy[0] && !flush;
    assign out_bus.valid = v[PIPE_DEPTH-1] && !flush;
    assign out_bus.data  = d[PIPE_DEPTH-1];

endmodule

// File: tb/tb_stdmacro_dffe_pipe.sv
// Bench for stdmacro_dffe_pipe: depth-3 and depth-1 instances share stimulus,
// each with its own FIFO scoreboard, plus directed latency/stall/flush/reset checks.
module tb_stdmacro_dffe_pipe;

    localparam int unsigned W   = 8;
    localparam logic [W-1:0] RST = 8'hA5;

    logic         clk       = 1'b0;
    logic         aresetn   = 1'b0;
    logic         flush     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data   = '0;

    int checks = 0;
    int errors = 0;

    logic [1:0]   rdy_o;
    logic [1:0]   vld_o;
    logic [W-1:0] dat_o [2];
    int           occ_o [2];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned D  = (g == 0) ? 3 : 1;
        localparam int unsigned CW = $clog2(D + 1);

        stdmacro_dffe_pipe_if #(.DFF_WIDTH(W)) in_bus ();
        stdmacro_dffe_pipe_if #(.DFF_WIDTH(W)) out_bus ();
        logic [CW-1:0] occ;
        logic [W-1:0]  sb [$];
        logic [W-1:0]  exp_d;

        assign in_bus.valid  = in_valid;
        assign in_bus.data   = in_data;
        assign out_bus.ready = out_ready;
        assign rdy_o[g]      = in_bus.ready;
        assign vld_o[g]      = out_bus.valid;
        assign dat_o[g]      = out_bus.data;
        assign occ_o[g]      = int'(occ);

        stdmacro_dffe_pipe #(
            .DFF_WIDTH   (W),
            .PIPE_DEPTH  (D),
            .RESET_VALUE (RST)
        ) u_dut (
            .clk       (clk),
            .aresetn   (aresetn),
            .flush     (flush),
            .in_bus    (in_bus),
            .out_bus   (out_bus),
            .occupancy (occ)
        );

        // Model: the pipe is a FIFO of at most D beats; flush and reset empty it.
        always @(negedge clk) begin
            if (!aresetn) begin
                sb.delete();
                check($sformatf("d%0d reset occupancy", D), 32'(occ), 32'd0);
                check($sformatf("d%0d reset out_valid", D), 32'(out_bus.valid), 32'd0);
                check($sformatf("d%0d reset out_data", D), 32'(out_bus.data), 32'(RST));
            end else begin
                check($sformatf("d%0d occupancy", D), 32'(occ), 32'(sb.size()));
                check($sformatf("d%0d in_ready", D), 32'(in_bus.ready),
                      32'(!flush && (sb.size() < D || out_ready)));
                if (flush) begin
                    check($sformatf("d%0d flush out_valid", D), 32'(out_bus.valid), 32'd0);
                end
                if (out_bus.valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL d%0d spurious output: got %0h expected no beat", D,
                                 out_bus.data);
                    end else begin
                        check($sformatf("d%0d out_data", D), 32'(out_bus.data), 32'(sb[0]));
                        if (out_ready) begin
                            exp_d = sb.pop_front();
                        end
                    end
                end
                if (in_valid && in_bus.ready) begin
                    sb.push_back(in_data);
                end
                if (flush) begin
                    sb.delete();
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;

        // Streaming 0x01..0x05 with no backpressure.
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 5);
            in_data  = W'(c + 1);
            @(negedge clk);
            check("stream d3 valid", 32'(vld_o[0]), 32'(c >= 3 && c <= 7));
            if (c >= 3 && c <= 7) check("stream d3 data", 32'(dat_o[0]), 32'(c - 2));
            if (c >= 3 && c <= 5) check("stream d3 occupancy", 32'(occ_o[0]), 32'd3);
            check("stream d1 valid", 32'(vld_o[1]), 32'(c >= 1 && c <= 5));
            if (c >= 1 && c <= 5) check("stream d1 data", 32'(dat_o[1]), 32'(c));
            if (c < 5) check("stream d1 in_ready", 32'(rdy_o[1]), 32'd1);
            step();
        end

        // Backpressure: fill depth 3, then release.
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int b = 1; b <= 3; b++) begin
            in_valid = 1'b1;
            in_data  = W'(b);
            @(negedge clk);
            check("bp accept", 32'(rdy_o[0]), 32'd1);
            step();
        end
        in_data = 8'h04;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp full in_ready", 32'(rdy_o[0]), 32'd0);
            check("bp full occupancy", 32'(occ_o[0]), 32'd3);
            step();
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("bp drain valid", 32'(vld_o[0]), 32'd1);
            check("bp drain data", 32'(dat_o[0]), 32'(k));
            step();
            in_valid = 1'b0;
        end
        repeat (4) step();

        // Bubble collapse toward a stalled output.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h0A;
        step();
        in_valid  = 1'b0;
        step();
        in_valid  = 1'b1;
        in_data   = 8'h0B;
        step();
        in_valid  = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("bubble occupancy", 32'(occ_o[0]), 32'd2);
        check("bubble in_ready", 32'(rdy_o[0]), 32'd1);
        check("bubble out_data", 32'(dat_o[0]), 32'h0A);
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h0C;
        @(negedge clk);
        check("bubble pop A", 32'(dat_o[0]), 32'h0A);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check("bubble adjacent B", 32'(vld_o[0]), 32'd1);
        check("bubble adjacent data", 32'(dat_o[0]), 32'h0B);
        check("pre-flush occupancy", 32'(occ_o[0]), 32'd2);
        step();

        // Flush with a beat offered and the consumer ready.
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush out_valid", 32'(vld_o), 32'd0);
        check("flush in_ready", 32'(rdy_o), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post-flush occupancy d3", 32'(occ_o[0]), 32'd0);
            check("post-flush out_valid", 32'(vld_o), 32'd0);
            step();
        end

        // Asynchronous reset with two beats in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        step();
        in_data   = 8'h22;
        step();
        in_valid  = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        check("areset out_valid", 32'(vld_o), 32'd0);
        check("areset occupancy d3", 32'(occ_o[0]), 32'd0);
        check("areset out_data d3", 32'(dat_o[0]), 32'(RST));
        in_valid = 1'b1;
        in_data  = 8'h33;
        repeat (2) step();
        aresetn  = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("post-reset occupancy d3", 32'(occ_o[0]), 32'd0);
        check("post-reset occupancy d1", 32'(occ_o[1]), 32'd0);
        step();

        // Random traffic with varying backpressure and occasional flush.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 99) < (((c / 500) % 2 == 1) ? 30 : 85));
            flush     = ($urandom_range(0, 40) == 0);
            step();
        end

        // Drain: every accepted beat must come out.
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) step();
        check("drain d3 leftover", 32'(g_dut[0].sb.size()), 32'd0);
        check("drain d1 leftover", 32'(g_dut[1].sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stdmacro_dffe_pipe.md
Name: stdmacro_dffe_pipe

Overview:
- Parametrised multi-stage pipeline register with a per-stage valid/ready handshake. It is the next generation of the enable-only DFF macro.
- Each stage is a DFF with enable. Stalls are applied per stage, empty stages (bubbles) collapse, and a synchronous flush is provided.
- Used for timing-cut and elastic buffering between Taurus 3001 pipeline units, e.g. decode to issue and LSU response return.

Parameters:
- DFF_WIDTH, 32: payload width in bits (>=1).
- PIPE_DEPTH, 2: number of register stages (>=1).
- RESET_VALUE, {DFF_WIDTH{1'b0}}: payload value loaded into every stage on reset.
- CNT_WIDTH, $clog2(PIPE_DEPTH+1): width of the occupancy output. Derived; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- aresetn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush; invalidates all stages.
- in_valid  in  1  upstream beat offered.
- in_ready  out  1  upstream beat accepted when in_valid && in_ready.
- in_data  in  DFF_WIDTH  upstream payload.
- out_valid  out  1  downstream beat available (last stage valid).
- out_ready  in  1  downstream accepts.
- out_data  out  DFF_WIDTH  last-stage payload.
- occupancy  out  CNT_WIDTH  number of valid stages.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While aresetn=0, immediately and independent of clk: all stage valids=0, all stage data=RESET_VALUE, out_valid=0, out_data=RESET_VALUE, occupancy=0.
  - in_ready is 1 during reset (combinational from the valids), but no beat is captured while reset is asserted.
  - Deassertion is assumed synchronised externally; the first capture edge is the first rising clk edge after aresetn goes high.
- Stage i (0 = input side, PIPE_DEPTH-1 = output side) holds v[i] and d[i].
- Ready chain (combinational, no registered skid):
  - rdy[PIPE_DEPTH-1] = !v[PIPE_DEPTH-1] || out_ready.
  - rdy[i] = !v[i] || rdy[i+1].
  - in_ready = rdy[0] && !flush.
- Stage i update on each rising clk when rdy[i]=1:
  - v[i] <= upstream valid (in_valid && !flush for i=0; v[i-1] for i>0).
  - d[i] <= upstream data, loaded only when the upstream valid is 1. This is the DFF enable; data is not rewritten on bubbles.
- When rdy[i]=0, the stage holds both v[i] and d[i].
- Bubble collapse: an empty stage always accepts, even when downstream is stalled. Gaps close at one stage per cycle.
- Latency: PIPE_DEPTH cycles from acceptance to out_valid when there is no backpressure. Throughput is 1 beat/cycle at any depth, including PIPE_DEPTH=1 (simultaneous drain and fill when full and out_ready=1).
- Ordering: strict FIFO. No beat is duplicated or dropped except by flush.
- Flush:
  - Has priority over everything except reset.
  - In the flush cycle, out_valid is forced to 0 and in_ready to 0; no handshake completes on either side.
  - At the next edge all v[i] <= 0. d[i] is retained (not cleared).
  - occupancy = 0 from the cycle after flush.
- occupancy: combinational popcount of v[]. Range 0..PIPE_DEPTH; never wraps.
- out_data is valid only when out_valid=1. It is otherwise stale but deterministic (last loaded value or RESET_VALUE).
- Simultaneous events:
  - flush with in_valid=1: the beat is dropped.
  - flush with out_ready=1: no output beat is counted.
  - Reset mid-stream: all in-flight beats are lost and no partial state remains.

Decomposition:
- Shared conf header (alongside the DFF conf macros):
  - ready-chain helper macro;
  - CNT_WIDTH derivation constant.
- One sub-module: stdmacro_dffe_pipe_stage.
  - Contents: single valid+data stage with enable, async active-low reset, RESET_VALUE.
  - Ports: clk, aresetn, en, up_valid, up_data, v, d.
- The top level generates PIPE_DEPTH instances, the ready chain and the popcount.

Test Plan:
- Async reset: pipe holding 2 beats, drop aresetn between edges → out_valid=0, occupancy=0, out_data=RESET_VALUE before the next edge; no capture until aresetn=1.
- Streaming: PIPE_DEPTH=3, out_ready=1, in_data=0x01..0x05 on consecutive cycles → out_data 0x01..0x05 on consecutive cycles starting 3 cycles after the first accept; occupancy steady at 3.
- Backpressure: out_ready=0, offer 4 beats at PIPE_DEPTH=3 → in_ready=0 after the 3rd accept, occupancy=3. Then out_ready=1 → 0x01,0x02,0x03,0x04 delivered in order with no gap.
- Bubble collapse: PIPE_DEPTH=3, send 0xA, idle 1 cycle, send 0xB, out_ready=0 → both beats advance until adjacent at the output end (occupancy=2, in_ready=1).
- Flush: occupancy=2, assert flush with in_valid=1 → out_valid=0 and in_ready=0 that cycle; next cycle occupancy=0 and the offered beat is absent from output.
- PIPE_DEPTH=1 full throughput: out_ready=1, in_valid=1 continuously → in_ready stays 1 and one beat/cycle is output, 1-cycle latency.
